dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the processor's data-memory port. It accepts load/store requests through a req/ack handshake, inserts a configurable number of wait states, and then performs a big-endian word access with byte enables on an internal word array. It returns read data with a one-cycle ack pulse. It replaces the zero-latency data memory so the datapath can be exercised against a slow, handshaked memory.

## Interface
- `DEPTH_LOG2`, default 6: log2 of the word count; the array is 64 words.
- `WAIT_CYCLES`, default 2: wait states between accepting a request and acking it. Legal range 0..15.

- `CLK`, in, 1: the only clock; all state changes on the rising edge.
- `Reset`, in, 1: synchronous, active-high.
- `req`, in, 1: request valid; the initiator holds it high until it sees `ack`.
- `we`, in, 1: 1 = store, 0 = load.
- `addr`, in, 32: byte address.
- `wdata`, in, 32: store data, big-endian lane order.
- `be`, in, 4: byte enables; `be[3]` is bits 31:24, which is the byte at `addr[1:0]` = 0.
- `ack`, out, 1: one-cycle completion pulse.
- `rdata`, out, 32: load data; valid while `ack` = 1 and `we` was 0.
- `err`, out, 1: access error; valid while `ack` = 1.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- **States:** IDLE, ACCESS, RESP.
- **IDLE:** `req` = 1 latches `we`, `addr`, `wdata` and `be`, loads `cnt` with WAIT_CYCLES, and moves to ACCESS. Input changes after this latch are ignored.
- **ACCESS with `cnt` != 0:** decrement `cnt`.
- **ACCESS with `cnt` = 0:** perform the access, set `ack` to 1, move to RESP.
  - Word index is `addr[DEPTH_LOG2+1:2]`. Upper address bits are ignored, so addresses alias and wrap modulo 4·2^DEPTH_LOG2 bytes.
  - Store: write only the lanes whose `be` bit is set. `be` = 0 leaves memory unchanged but still acks.
  - Load: return the full word in `rdata` regardless of `be`.
  - Store: `rdata` keeps its previous value.
- **RESP:** clear `ack`, move to IDLE. `req` is ignored while in RESP.
- **Error:** when `err` = 1 (see Configuration), the store is suppressed and `rdata` is 0.
- **Memory contents:** not affected by `Reset`. The array powers up as zero in simulation.
- **Priority:** `Reset` beats everything. `Reset` at the completing edge means no write, no `ack`, and the state goes to IDLE.

## Timing
- **Reset values:** state IDLE, `ack` 0, `rdata` 0x00000000, `err` 0, `busy` 0, `cnt` 0.
- **Latency:** `req` sampled at edge k ⇒ `ack` high from edge k+1+WAIT_CYCLES to edge k+2+WAIT_CYCLES, which is exactly one cycle.
- **Back-to-back:** the next request can be sampled at edge k+3+WAIT_CYCLES at the earliest. Minimum period is WAIT_CYCLES+3 cycles.
- **Initiator obligations:**
  - Keep `req` high until the `ack` cycle.
  - Deassert it at the edge that ends `ack` unless issuing a new request.
  - A request still high when the state returns to IDLE is treated as a new transaction.
- **`busy` timing:** `busy` rises at edge k and falls at edge k+2+WAIT_CYCLES.
- **Reset mid-transaction:** the transaction is abandoned and is never acked. The initiator must re-issue it.
- **Read/write ordering:** store data is visible to any load whose access edge is later. There is no read-during-write case, because only one transaction is outstanding.

## Configuration
- **`DMEM_ALIGN_CHECK_EN` defined:** `err` = 1 unless (`be`, `addr[1:0]`) is one of the following pairs.
  - 1111 with 00.
  - 1100 with 00.
  - 0011 with 10.
  - One-hot `be` matching the byte: 1000 with 00, 0100 with 01, 0010 with 10, 0001 with 11.
  - `be` = 0000 with any address.
- **`DMEM_ALIGN_CHECK_EN` not defined:**
  - `err` is tied to 0.
  - `addr[1:0]` is ignored.
  - `be` is applied exactly as given.

## Test plan
- **Store/load:** Reset, then WAIT_CYCLES=2; store 0xDEADBEEF to 0x10 with `be` = 1111. Expect `ack` exactly 3 edges after sampling, lasting 1 cycle, with `err` = 0. Then load 0x10 ⇒ `rdata` = 0xDEADBEEF with `ack`.
- **Byte store:** store `be` = 0100, `addr` = 0x11, `wdata` = 0x00AB0000. Load 0x10 ⇒ 0xDEABBEEF.
- **Alignment error (`DMEM_ALIGN_CHECK_EN` defined):** store `be` = 1111 to 0x12 ⇒ `ack` with `err` = 1; load 0x10 still returns 0xDEABBEEF. With the macro not defined, the same store writes word 0x10 ⇒ 0x12345678 (using `wdata` = 0x12345678).
- **Reset mid-write:** store 0x55AA55AA to 0x20, and assert `Reset` on the cycle after the request is accepted. Expect no `ack`, `busy` = 0 after the reset edge, and a load of 0x20 returning 0x00000000.
- **Wrap and zero wait:** with DEPTH_LOG2=6, store 0xCAFEF00D to 0x100, then load 0x000 ⇒ 0xCAFEF00D. With WAIT_CYCLES=0, `ack` is at k+1, and two requests with `req` held continuously are acked 3 cycles apart.

Source files
------------

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: req/ack with WAIT_CYCLES wait states, big-endian byte-enabled word array.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam int NWORDS = 1 << DEPTH_LOG2;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  we_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;
  logic                  access_err;
  logic                  do_access;
  logic                  unused_addr;

  logic [31:0] mem [0:NWORDS-1];

  assign busy      = (state != IDLE);
  assign do_access = (state == ACCESS) && (cnt == 4'd0);

`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0] off_q;

  always_ff @(posedge CLK) begin
    if (state == IDLE && req) off_q <= addr[1:0];
  end

  // Only naturally aligned word, halfword and byte accesses are legal; be=0 is a no-op.
  always_comb begin
    access_err = 1'b1;
    case ({be_q, off_q})
      6'b1111_00, 6'b1100_00, 6'b0011_10,
      6'b1000_00, 6'b0100_01, 6'b0010_10, 6'b0001_11: access_err = 1'b0;
      default: access_err = (be_q != 4'b0000);
    endcase
  end

  assign unused_addr = ^addr[31:DEPTH_LOG2+2];
`else
  assign access_err  = 1'b0;
  assign unused_addr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};
`endif

  // Request fields are captured once at acceptance; later input changes are ignored.
  always_ff @(posedge CLK) begin
    if (state == IDLE && req) begin
      we_q    <= we;
      idx_q   <= addr[DEPTH_LOG2+1:2];
      wdata_q <= wdata;
      be_q    <= be;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ack   <= 1'b0;
      rdata <= 32'h0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cnt   <= WAIT_INIT;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            ack   <= 1'b1;
            err   <= access_err;
            state <= RESP;
            if (access_err)  rdata <= 32'h0;
            else if (!we_q)  rdata <= mem[idx_q];
          end
        end
        RESP: begin
          ack   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory has no reset; a reset at the access edge suppresses the write.
  always_ff @(posedge CLK) begin
    if (!Reset && do_access && we_q && !access_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized + directed bench for dmem_responder against a transaction-level model.
module tb_dmem_responder;
  localparam int D  = 6;
  localparam int W  = 2;
  localparam int NW = 1 << D;

  logic        CLK = 1'b0;
  logic        Reset, req, we, ack, err, busy;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        req0, we0, ack0, err0, busy0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0]  be0;

  always #5 CLK = ~CLK;

  dmem_responder #(.DEPTH_LOG2(D), .WAIT_CYCLES(W)) u_dut (
    .CLK(CLK), .Reset(Reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ack(ack), .rdata(rdata), .err(err), .busy(busy));

  dmem_responder #(.DEPTH_LOG2(D), .WAIT_CYCLES(0)) u_dut0 (
    .CLK(CLK), .Reset(Reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0), .be(be0),
    .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0));

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Transaction-level model: a request accepted at edge k completes at k+1+W, idle again at k+2+W.
  logic [31:0] mmem [NW];
  int          e = 0, ack_e = -1, free_at = 0;
  bit          pend = 0;
  bit          m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  bit          exp_ack = 0, exp_err = 0, exp_busy = 0, exp_load = 0;
  logic [31:0] exp_rdata = 32'h0;

  function automatic bit model_err(input logic [3:0] b, input logic [1:0] o);
`ifdef DMEM_ALIGN_CHECK_EN
    if (b == 4'b0000) return 1'b0;
    if (b == 4'b1111 || b == 4'b1100) return o != 2'd0;
    if (b == 4'b0011) return o != 2'd2;
    if ($onehot(b)) return b != (4'b1000 >> o);
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    for (int i = 0; i < NW; i++) mmem[i] = 32'h0;
    forever begin
      @(posedge CLK);
      e++;
      exp_ack = 0;
      if (Reset) begin
        pend = 0; free_at = e; exp_busy = 0; exp_rdata = 32'h0; exp_err = 0;
      end else begin
        if (pend && e == ack_e) begin
          int  idx;
          bit  er;
          idx = int'(m_addr[D+1:2]);
          er  = model_err(m_be, m_addr[1:0]);
          if (m_we && !er)
            for (int i = 0; i < 4; i++) if (m_be[i]) mmem[idx][8*i +: 8] = m_wdata[8*i +: 8];
          if (er) exp_rdata = 32'h0;
          else if (!m_we) exp_rdata = mmem[idx];
          exp_err = er; exp_load = !m_we; exp_ack = 1; pend = 0;
        end else if (!pend && e >= free_at && req) begin
          m_we = we; m_addr = addr; m_wdata = wdata; m_be = be;
          pend = 1; ack_e = e + 1 + W; free_at = e + 2 + W;
        end
        exp_busy = pend || (e < free_at);
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      check("ack", ack, exp_ack);
      check("busy", busy, exp_busy);
      if (exp_ack) begin
        check("err", err, exp_err);
        if (exp_load) check("rdata", rdata, exp_rdata);
      end
    end
  end

  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                     output logic [31:0] rd, output logic er, output int lat);
    bit got;
    got = 0; rd = 32'hx; er = 1'bx;
    @(negedge CLK);
    we = w; addr = a; wdata = d; be = b; req = 1; lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      lat++;
      if (i == 0) begin
        wdata = $urandom; addr = $urandom; be = 4'($urandom); we = 1'($urandom);
      end
      if (ack) begin
        rd = rdata; er = err; req = 0; got = 1;
        break;
      end
    end
    if (!got) begin
      n_vec++; n_bad++; req = 0;
      $display("FAIL txn_timeout: no ack for addr %h", a);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a;
    logic        er;
    logic [3:0]  b;
    int          lat, t1, t2;
    logic [3:0]  legal [8];
    legal = '{4'b1111, 4'b1100, 4'b0011, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};

    Reset = 1; req = 0; we = 0; addr = 0; wdata = 0; be = 0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; be0 = 0;
    repeat (3) @(negedge CLK);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_busy0", busy0, 0);
    Reset = 0;

    for (int i = 0; i < NW; i++) txn(1, 32'(i * 4), 32'h0, 4'hF, rd, er, lat);

    txn(1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check("st_latency", 32'(lat), 32'd4);
    check("st_err", er, 0);
    txn(0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("ld_10", rd, 32'hDEADBEEF);

    txn(1, 32'h11, 32'h00AB0000, 4'b0100, rd, er, lat);
    txn(0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    check("ld_byte", rd, 32'hDEABBEEF);

    txn(1, 32'h12, 32'h12345678, 4'hF, rd, er, lat);
    txn(0, 32'h10, 32'h0, 4'hF, rd, b[0], lat);
`ifdef DMEM_ALIGN_CHECK_EN
    check("align_err", er, 1);
    check("align_ld", rd, 32'hDEABBEEF);
`else
    check("align_err", er, 0);
    check("align_ld", rd, 32'h12345678);
`endif

    @(negedge CLK);
    we = 1; addr = 32'h20; wdata = 32'h55AA55AA; be = 4'hF; req = 1;
    @(negedge CLK);
    Reset = 1; req = 0;
    @(negedge CLK);
    check("rst_mid_busy", busy, 0);
    Reset = 0;
    repeat (W + 3) begin
      @(negedge CLK);
      check("rst_mid_noack", ack, 0);
    end
    txn(0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    check("rst_mid_ld", rd, 32'h0);

    txn(1, 32'h100, 32'hCAFEF00D, 4'hF, rd, er, lat);
    txn(0, 32'h000, 32'h0, 4'hF, rd, er, lat);
    check("wrap_ld", rd, 32'hCAFEF00D);

    for (int n = 0; n < 200; n++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      b = ($urandom_range(0, 1) != 0) ? legal[$urandom_range(0, 7)] : 4'($urandom);
      txn(1'($urandom), a, $urandom, b, rd, er, lat);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    // Zero-wait instance: two requests with req held continuously.
    t1 = -1; t2 = -1; rd = 32'h0;
    @(negedge CLK);
    we0 = 1; addr0 = 32'h40; wdata0 = 32'hCAFEF00D; be0 = 4'hF; req0 = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (ack0) begin
        if (t1 < 0) begin
          t1 = i; we0 = 0;
        end else begin
          t2 = i; rd = rdata0; er = err0; req0 = 0;
          break;
        end
      end
    end
    req0 = 0;
    check("w0_first_ack", 32'(t1), 32'd2);
    check("w0_ack_spacing", 32'(t2 - t1), 32'd3);
    check("w0_ld", rd, 32'hCAFEF00D);
    check("w0_err", er, 0);

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
